// File: rtl/bypass_network.sv
// bypass_network: operand forwarding from a shift history of in-flight integer producers.
// Latency: lookup select registered one cycle; forwarded value is combinational from entry state.
// Backpressure: i_stall freezes history, selects and counters; BYPASS_NETWORK_STATS_EN adds counters.
module bypass_network #(
  parameter int XLEN           = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int NUM_STAGES     = 3,
  parameter int REG_ADDR_W     = 5,
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_stall,
  input  logic [NUM_STAGES-1:0]            i_flush_mask,
  input  logic                             i_push_valid,
  input  logic [REG_ADDR_W-1:0]            i_push_rd,
  input  logic                             i_push_data_ready,
  input  logic [XLEN-1:0]                  i_push_data,
  input  logic                             i_fill_valid,
  input  logic [IW-1:0]                    i_fill_index,
  input  logic [XLEN-1:0]                  i_fill_data,
  input  logic [NUM_READ_PORTS*REG_ADDR_W-1:0] i_rs_addr,
  input  logic [NUM_READ_PORTS*XLEN-1:0]   i_rf_data,
  output logic [NUM_READ_PORTS*XLEN-1:0]   o_value,
  output logic [NUM_READ_PORTS-1:0]        o_not_ready,
  output logic                             o_retire_valid,
  output logic [REG_ADDR_W-1:0]            o_retire_rd,
  output logic [XLEN-1:0]                  o_retire_data
`ifdef BYPASS_NETWORK_STATS_EN
  ,
  output logic [31:0]                      o_fwd_count,
  output logic [31:0]                      o_notready_count
`endif
);

  // History entries: index 0 is the youngest producer, NUM_STAGES-1 the oldest
  logic [NUM_STAGES-1:0] ent_valid, ent_ready;
  logic [REG_ADDR_W-1:0] ent_rd   [NUM_STAGES];
  logic [XLEN-1:0]       ent_data [NUM_STAGES];

  logic [NUM_STAGES-1:0] fil_ready;
  logic [XLEN-1:0]       fil_data [NUM_STAGES];
  logic [NUM_STAGES-1:0] nxt_valid, nxt_ready;
  logic [REG_ADDR_W-1:0] nxt_rd   [NUM_STAGES];
  logic [XLEN-1:0]       nxt_data [NUM_STAGES];

  // Registered per-port select into the history
  logic [NUM_READ_PORTS-1:0] sel_valid, nxt_sel_valid;
  logic [IW-1:0]             sel_idx     [NUM_READ_PORTS];
  logic [IW-1:0]             nxt_sel_idx [NUM_READ_PORTS];

  // Apply the late fill to the pre-shift view, then shift (or hold while stalled), then flush.
  // Fills and flushes are still honoured during a stall so a returning load is never lost.
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      fil_ready[k] = ent_ready[k];
      fil_data[k]  = ent_data[k];
      if (i_fill_valid && ent_valid[k] && (i_fill_index == IW'(k))) begin
        fil_ready[k] = 1'b1;
        fil_data[k]  = i_fill_data;
      end
    end
    nxt_valid = ent_valid;
    nxt_ready = fil_ready;
    for (int k = 0; k < NUM_STAGES; k++) begin
      nxt_rd[k]   = ent_rd[k];
      nxt_data[k] = fil_data[k];
    end
    if (!i_stall) begin
      nxt_valid[0] = i_push_valid && (i_push_rd != '0);
      nxt_ready[0] = i_push_data_ready;
      nxt_rd[0]    = i_push_rd;
      nxt_data[0]  = i_push_data;
      for (int k = 1; k < NUM_STAGES; k++) begin
        nxt_valid[k] = ent_valid[k-1];
        nxt_ready[k] = fil_ready[k-1];
        nxt_rd[k]    = ent_rd[k-1];
        nxt_data[k]  = fil_data[k-1];
      end
    end
    nxt_valid = nxt_valid & ~i_flush_mask;
  end

  // Early lookup: youngest matching entry, re-based to where it will sit after this cycle's shift
  always_comb begin
    int   pos;
    logic hit;
    logic flushed;
    pos     = 0;
    hit     = 1'b0;
    flushed = 1'b0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      hit = 1'b0;
      pos = 0;
      for (int k = NUM_STAGES - 1; k >= 0; k--) begin
        if (ent_valid[k] && (ent_rd[k] == i_rs_addr[p*REG_ADDR_W +: REG_ADDR_W])) begin
          hit = 1'b1;
          pos = k;
        end
      end
      if (i_rs_addr[p*REG_ADDR_W +: REG_ADDR_W] == '0) hit = 1'b0;
      if (i_stall) begin
        flushed = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++)
          if (sel_idx[p] == IW'(k)) flushed = i_flush_mask[k];
        nxt_sel_valid[p] = sel_valid[p] && !flushed;
        nxt_sel_idx[p]   = sel_idx[p];
      end else begin
        if (pos == NUM_STAGES - 1) hit = 1'b0;
        else                       pos = pos + 1;
        flushed = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++)
          if (pos == k) flushed = i_flush_mask[k];
        nxt_sel_valid[p] = hit && !flushed;
        nxt_sel_idx[p]   = (hit && !flushed) ? IW'(pos) : '0;
      end
    end
  end

  // Operand mux: live entry data when a producer is selected, otherwise the register file value
  always_comb begin
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      o_value[p*XLEN +: XLEN] = i_rf_data[p*XLEN +: XLEN];
      o_not_ready[p]          = 1'b0;
      if (sel_valid[p]) begin
        o_value[p*XLEN +: XLEN] = ent_data[sel_idx[p]];
        o_not_ready[p]          = !ent_ready[sel_idx[p]];
      end
    end
  end

  assign o_retire_valid = !i_stall && ent_valid[NUM_STAGES-1];
  assign o_retire_rd    = ent_rd[NUM_STAGES-1];
  assign o_retire_data  = ent_data[NUM_STAGES-1];

  // History and select registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ent_valid <= '0;
      ent_ready <= '0;
      sel_valid <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        ent_rd[k]   <= '0;
        ent_data[k] <= '0;
      end
      for (int p = 0; p < NUM_READ_PORTS; p++) sel_idx[p] <= '0;
    end else begin
      ent_valid <= nxt_valid;
      ent_ready <= nxt_ready;
      sel_valid <= nxt_sel_valid;
      for (int k = 0; k < NUM_STAGES; k++) begin
        ent_rd[k]   <= nxt_rd[k];
        ent_data[k] <= nxt_data[k];
      end
      for (int p = 0; p < NUM_READ_PORTS; p++) sel_idx[p] <= nxt_sel_idx[p];
    end
  end

`ifdef BYPASS_NETWORK_STATS_EN
  logic [32:0] fwd_sum, nr_sum;

  // Per-cycle increments; the extra top bit flags saturation
  always_comb begin
    fwd_sum = {1'b0, o_fwd_count};
    nr_sum  = {1'b0, o_notready_count};
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      fwd_sum = fwd_sum + {32'd0, sel_valid[p]};
      nr_sum  = nr_sum + {32'd0, o_not_ready[p]};
    end
  end

  // Saturating forward / not-ready counters, frozen while stalled
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_fwd_count      <= '0;
      o_notready_count <= '0;
    end else if (!i_stall) begin
      o_fwd_count      <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
      o_notready_count <= nr_sum[32] ? 32'hFFFF_FFFF : nr_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_bypass_network.sv
// tb_bypass_network: directed vector table plus a mid-stream reset sequence for bypass_network.
// Each table row is one clock: inputs driven after the edge, outputs sampled mid-cycle.
// Default parameters: 2 read ports, 3 stages, 32-bit data.
module tb_bypass_network;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  flush_mask;
  logic        push_valid;
  logic [4:0]  push_rd;
  logic        push_data_ready;
  logic [31:0] push_data;
  logic        fill_valid;
  logic [1:0]  fill_index;
  logic [31:0] fill_data;
  logic [9:0]  rs_addr;
  logic [63:0] rf_data;
  logic [63:0] value;
  logic [1:0]  not_ready;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic [31:0] retire_data;
`ifdef BYPASS_NETWORK_STATS_EN
  logic [31:0] fwd_count, notready_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bypass_network dut (
    .i_clk(clk), .i_reset(reset), .i_stall(stall), .i_flush_mask(flush_mask),
    .i_push_valid(push_valid), .i_push_rd(push_rd), .i_push_data_ready(push_data_ready),
    .i_push_data(push_data), .i_fill_valid(fill_valid), .i_fill_index(fill_index),
    .i_fill_data(fill_data), .i_rs_addr(rs_addr), .i_rf_data(rf_data),
    .o_value(value), .o_not_ready(not_ready), .o_retire_valid(retire_valid),
    .o_retire_rd(retire_rd), .o_retire_data(retire_data)
`ifdef BYPASS_NETWORK_STATS_EN
    , .o_fwd_count(fwd_count), .o_notready_count(notready_count)
`endif
  );

  typedef struct {
    logic        stall;
    logic [2:0]  flush;
    logic        pv;
    logic [4:0]  prd;
    logic [31:0] pdat;
    logic        prdy;
    logic        fv;
    logic [1:0]  fidx;
    logic [31:0] fdat;
    logic [4:0]  rs0, rs1;
    logic [31:0] rf0, rf1;
    logic [31:0] e0, e1;
    logic [1:0]  enr;
    logic        erv;
    logic [4:0]  erd;
    logic [31:0] edat;
  } tv_t;

  tv_t tv[$];
  tv_t r;

  function automatic tv_t mk(input logic pv, input logic [4:0] prd, input logic [31:0] pdat,
                             input logic prdy, input logic [4:0] rs0, input logic [4:0] rs1,
                             input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] enr,
                             input logic erv, input logic [4:0] erd, input logic [31:0] edat);
    tv_t t;
    t.stall = 1'b0; t.flush = 3'b000; t.fv = 1'b0; t.fidx = 2'd0; t.fdat = 32'd0;
    t.pv = pv; t.prd = prd; t.pdat = pdat; t.prdy = prdy;
    t.rs0 = rs0; t.rs1 = rs1; t.rf0 = 32'hAA; t.rf1 = 32'hBB;
    t.e0 = e0; t.e1 = e1; t.enr = enr; t.erv = erv; t.erd = erd; t.edat = edat;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, got, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush_mask = 3'b000; push_valid = 1'b0; push_rd = 5'd0;
    push_data_ready = 1'b0; push_data = 32'd0; fill_valid = 1'b0; fill_index = 2'd0;
    fill_data = 32'd0; rs_addr = 10'd0; rf_data = {32'hBB, 32'hAA};
  endtask

  task automatic apply(input tv_t t);
    stall = t.stall; flush_mask = t.flush; push_valid = t.pv; push_rd = t.prd;
    push_data_ready = t.prdy; push_data = t.pdat; fill_valid = t.fv; fill_index = t.fidx;
    fill_data = t.fdat; rs_addr = {t.rs1, t.rs0}; rf_data = {t.rf1, t.rf0};
  endtask

  task automatic do_push(input logic [4:0] rd, input logic [31:0] d);
    idle_inputs();
    push_valid = 1'b1; push_rd = rd; push_data = d; push_data_ready = 1'b1;
  endtask

  initial begin
    // Vector table: outputs expected within the same cycle the inputs are applied
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 0 reset state
    tv.push_back(mk(1, 5, 32'h11, 1,     0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 1 push rd5
    tv.push_back(mk(0, 0, 0, 0,          5, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 2 lookup 5
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'h11, 32'hBB, 2'b00, 0, 0, 0));            // 3 forwarded
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 1, 5, 32'h11));       // 4 retire 5
    tv.push_back(mk(1, 7, 32'h1, 1,      0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 5
    tv.push_back(mk(1, 7, 32'h2, 1,      0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 6
    tv.push_back(mk(0, 0, 0, 0,          7, 7,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 7 lookup 7 both
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'h2,  32'h2,  2'b00, 1, 7, 32'h1));        // 8 youngest wins
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 1, 7, 32'h2));        // 9
    tv.push_back(mk(1, 7, 32'h3, 1,      0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 10
    tv.push_back(mk(1, 1, 32'h101, 1,    0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 11
    tv.push_back(mk(1, 2, 32'h102, 1,    0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 12
    tv.push_back(mk(1, 3, 32'h103, 1,    0, 0,  32'hAA, 32'hBB, 2'b00, 1, 7, 32'h3));        // 13
    tv.push_back(mk(1, 4, 32'h104, 1,    0, 0,  32'hAA, 32'hBB, 2'b00, 1, 1, 32'h101));      // 14
    tv.push_back(mk(0, 0, 0, 0,          7, 3,  32'hAA, 32'hBB, 2'b00, 1, 2, 32'h102));      // 15 7 gone, 3 oldest-but-one
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'h103, 2'b00, 1, 3, 32'h103));     // 16
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 1, 4, 32'h104));      // 17
    tv.push_back(mk(1, 9, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 18 load rd9
    tv.push_back(mk(0, 0, 0, 0,          9, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 19 lookup 9
    r = mk(0, 0, 0, 0,                   9, 0,  32'h0,  32'hBB, 2'b01, 0, 0, 0);             // 20 not ready + fill
    r.fv = 1'b1; r.fidx = 2'd1; r.fdat = 32'hDEAD; tv.push_back(r);
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hDEAD, 32'hBB, 2'b00, 1, 9, 32'hDEAD));   // 21 fill visible
    tv.push_back(mk(1, 8, 32'h108, 1,    0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 22
    tv.push_back(mk(1, 9, 32'h99, 1,     0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 23
    tv.push_back(mk(1, 10, 32'h10A, 1,   9, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 24 lookup 9
    for (int s = 0; s < 3; s++) begin                                                         // 25-27 stall
      r = mk(1, 11, 32'h10B, 1,          9, 0,  32'h99, 32'hBB, 2'b00, 0, 0, 0);
      r.stall = 1'b1; tv.push_back(r);
    end
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'h99, 32'hBB, 2'b00, 1, 8, 32'h108));      // 28 release
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 1, 9, 32'h99));       // 29
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 1, 10, 32'h10A));     // 30
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 31
    tv.push_back(mk(1, 0, 32'hFF, 1,     0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 32 push x0
    r = mk(0, 0, 0, 0,                   0, 0,  32'h0,  32'hBB, 2'b00, 0, 0, 0);             // 33 lookup x0
    r.rf0 = 32'h0; tv.push_back(r);
    tv.push_back(r);                                                                          // 34
    tv.push_back(mk(1, 12, 32'h10C, 1,   0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 35
    r = mk(0, 0, 0, 0,                   12, 12, 32'hAA, 32'hBB, 2'b00, 0, 0, 0);            // 36 lookup + flush
    r.flush = 3'b111; tv.push_back(r);
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 37
    tv.push_back(mk(1, 13, 32'h10D, 1,   0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 38
    tv.push_back(mk(0, 0, 0, 0,          13, 0, 32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 39
    r = mk(0, 0, 0, 0,                   0, 0,  32'h10D, 32'hBB, 2'b00, 0, 0, 0);            // 40 flush under select
    r.flush = 3'b111; tv.push_back(r);
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 41
    tv.push_back(mk(1, 14, 32'h10E, 0,   0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 42 load rd14
    r = mk(0, 0, 0, 0,                   14, 0, 32'hAA, 32'hBB, 2'b00, 0, 0, 0);             // 43 fill invalid entry
    r.fv = 1'b1; r.fidx = 2'd1; r.fdat = 32'hDEAD; tv.push_back(r);
    r = mk(0, 0, 0, 0,                   14, 0, 32'h10E, 32'hBB, 2'b01, 0, 0, 0);            // 44 flush beats fill
    r.fv = 1'b1; r.fidx = 2'd1; r.fdat = 32'hBEEF; r.flush = 3'b100; tv.push_back(r);
    tv.push_back(mk(0, 0, 0, 0,          0, 0,  32'hAA, 32'hBB, 2'b00, 0, 0, 0));            // 45

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
`ifdef BYPASS_NETWORK_STATS_EN
    #4;
    chk("fwd_count_reset", -1, {32'd0, fwd_count}, 64'd0);
    chk("notready_count_reset", -1, {32'd0, notready_count}, 64'd0);
    @(posedge clk); #1;
`endif

    foreach (tv[i]) begin
      apply(tv[i]);
      #4;
      chk("value", i, value, {tv[i].e1, tv[i].e0});
      chk("not_ready", i, {62'd0, not_ready}, {62'd0, tv[i].enr});
      chk("retire_valid", i, {63'd0, retire_valid}, {63'd0, tv[i].erv});
      if (tv[i].erv) begin
        chk("retire_rd", i, {59'd0, retire_rd}, {59'd0, tv[i].erd});
        chk("retire_data", i, {32'd0, retire_data}, {32'd0, tv[i].edat});
      end
      @(posedge clk); #1;
    end

    // Reset mid-stream with three valid entries and live selects
    do_push(5'd20, 32'h114); @(posedge clk); #1;
    do_push(5'd21, 32'h115); @(posedge clk); #1;
    do_push(5'd22, 32'h116); @(posedge clk); #1;
    do_push(5'd23, 32'h117); rs_addr = {5'd21, 5'd22}; @(posedge clk); #1;
    idle_inputs(); rs_addr = {5'd21, 5'd22}; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; rs_addr = {5'd23, 5'd22};
    #4;
    chk("value_after_reset", 100, value, {32'hBB, 32'hAA});
    chk("not_ready_after_reset", 100, {62'd0, not_ready}, 64'd0);
    chk("retire_valid_after_reset", 100, {63'd0, retire_valid}, 64'd0);
`ifdef BYPASS_NETWORK_STATS_EN
    chk("fwd_count_after_reset", 100, {32'd0, fwd_count}, 64'd0);
    chk("notready_count_after_reset", 100, {32'd0, notready_count}, 64'd0);
`endif
    @(posedge clk); #1;
    rs_addr = 10'd0;
    #4;
    chk("value_post_reset_lookup", 101, value, {32'hBB, 32'hAA});
    chk("retire_valid_post_reset", 101, {63'd0, retire_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
